// File: rtl/decode_pkg.sv
// decode_pkg: shared decode definitions for the decode stage.
//   - RV32 base opcode constants
//   - instruction format enum (encoding is visible on out_fmt)
//   - immediate generator used by the decode stage
package decode_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    // 32-bit sign-extended immediate; R-format (and illegal, which decodes
    // as R) yields zero.
    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input fmt_e fmt);
        case (fmt)
            FMT_I:   return {{20{instr[31]}}, instr[31:20]};
            FMT_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   return {instr[31:12], 12'b0};
            FMT_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_if.sv
// decode_if: bundle of all handshake/data signals around the decode stage.
//   fetch side     : in_valid, in_ready, in_pc, in_instr, flush
//   execute side   : out_valid, out_ready, out_* decoded fields
//   writeback side : wb_en, wb_rd, wb_data
// Modport slave is the decode stage; master is its environment.
interface decode_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_instr;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_rs1_data;
    logic [XLEN-1:0] out_rs2_data;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rd;
    logic [2:0]      out_funct3;
    logic            out_funct7b5;
    logic [6:0]      out_opcode;
    logic [2:0]      out_fmt;
    logic            out_illegal;

    logic            wb_en;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready, wb_en, wb_rd, wb_data,
        output in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_funct3, out_funct7b5, out_opcode, out_fmt, out_illegal
    );

    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready, wb_en, wb_rd, wb_data,
        input  in_ready, out_valid, out_pc, out_rs1_data, out_rs2_data, out_imm,
               out_rd, out_funct3, out_funct7b5, out_opcode, out_fmt, out_illegal
    );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: NREG x XLEN register file.
//   clk, rst           : clock, synchronous active-high clear of all entries
//   rs1_idx / rs1_data : combinational read port 1
//   rs2_idx / rs2_data : combinational read port 2
//   wb_en, wb_rd, wb_data : synchronous write port
// Entry 0 is hardwired to zero. A read of the index being written in the
// same cycle returns the write data, so the reader never sees stale data.
module decode_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   rs1_idx,
    input  logic [AW-1:0]   rs2_idx,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wb_en && (wb_rd != '0)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs[rs1_idx];
        rs2_data = regs[rs2_idx];
        if (wb_en && (wb_rd == rs1_idx)) rs1_data = wb_data;
        if (wb_en && (wb_rd == rs2_idx)) rs2_data = wb_data;
        // x0 wins over the bypass: a write to x0 is discarded.
        if (rs1_idx == '0) rs1_data = '0;
        if (rs2_idx == '0) rs2_data = '0;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: instruction decode between fetch and execute.
//   clk, rst : clock, synchronous active-high reset
//   bus      : decode_if.slave carrying the fetch handshake (in_*, flush),
//              the registered decoded bundle to execute (out_*), and the
//              writeback port into the internal register file (wb_*).
// One output register with one-entry storage; in_ready is combinational
// (!out_valid || out_ready), so a stalled bundle blocks fetch directly.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic clk,
    input  logic rst,
    decode_if.slave bus
);
    localparam int AW = $clog2(NREG);

    logic            accept;
    logic [6:0]      opcode;
    fmt_e            fmt_d;
    logic            illegal_d;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    logic            vld_p1;
    logic [XLEN-1:0] pc_p1;
    logic [XLEN-1:0] rs1_p1;
    logic [XLEN-1:0] rs2_p1;
    logic [XLEN-1:0] imm_p1;
    logic [4:0]      rd_p1;
    logic [2:0]      funct3_p1;
    logic            funct7b5_p1;
    logic [6:0]      opcode_p1;
    fmt_e            fmt_p1;
    logic            illegal_p1;

    decode_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_idx  (bus.in_instr[15 +: AW]),
        .rs2_idx  (bus.in_instr[20 +: AW]),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .wb_en    (bus.wb_en),
        .wb_rd    (bus.wb_rd[AW-1:0]),
        .wb_data  (bus.wb_data)
    );

    // ---- stage p0: combinational decode of the presented instruction ----
    assign opcode      = bus.in_instr[6:0];
    assign bus.in_ready = !vld_p1 || bus.out_ready;
    assign accept      = bus.in_valid && bus.in_ready && !bus.flush;

    always_comb begin
        fmt_d     = FMT_R;
        illegal_d = 1'b0;
        case (opcode)
            OP_R:                      fmt_d = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR:  fmt_d = FMT_I;
            OP_STORE:                  fmt_d = FMT_S;
            OP_BRANCH:                 fmt_d = FMT_B;
            OP_LUI, OP_AUIPC:          fmt_d = FMT_U;
            OP_JAL:                    fmt_d = FMT_J;
            default:                   illegal_d = 1'b1;
        endcase
        imm_d = XLEN'(signed'(imm_gen(bus.in_instr, fmt_d)));
    end

    // ---- stage p1: output register toward execute ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            pc_p1       <= '0;
            rs1_p1      <= '0;
            rs2_p1      <= '0;
            imm_p1      <= '0;
            rd_p1       <= '0;
            funct3_p1   <= '0;
            funct7b5_p1 <= 1'b0;
            opcode_p1   <= '0;
            fmt_p1      <= FMT_R;
            illegal_p1  <= 1'b0;
        end else if (bus.flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            pc_p1       <= bus.in_pc;
            rs1_p1      <= rs1_data;
            rs2_p1      <= rs2_data;
            imm_p1      <= imm_d;
            rd_p1       <= bus.in_instr[11:7];
            funct3_p1   <= bus.in_instr[14:12];
            funct7b5_p1 <= bus.in_instr[30];
            opcode_p1   <= opcode;
            fmt_p1      <= fmt_d;
            illegal_p1  <= illegal_d;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid    = vld_p1;
    assign bus.out_pc       = pc_p1;
    assign bus.out_rs1_data = rs1_p1;
    assign bus.out_rs2_data = rs2_p1;
    assign bus.out_imm      = imm_p1;
    assign bus.out_rd       = rd_p1;
    assign bus.out_funct3   = funct3_p1;
    assign bus.out_funct7b5 = funct7b5_p1;
    assign bus.out_opcode   = opcode_p1;
    assign bus.out_fmt      = fmt_p1;
    assign bus.out_illegal  = illegal_p1;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scenarios followed by randomized traffic, all
// checked against a behavioural model of the decode stage and its register
// file kept in this bench.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst;

    decode_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference state
    logic [31:0] m_regs [32];
    logic        m_vld;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3, m_fmt;
    logic        m_f7, m_ill;
    logic [6:0]  m_op;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Format and immediate computed arithmetically from the instruction word.
    function automatic void ref_decode(input logic [31:0] ins, output logic [2:0] fmt,
                                       output logic ill, output logic [31:0] imm);
        logic signed [31:0] s;
        s   = signed'(ins);
        ill = 1'b0;
        fmt = 3'd0;
        imm = 32'd0;
        case (ins[6:0])
            7'h33: ;
            7'h13, 7'h03, 7'h67: begin
                fmt = 3'd1;
                imm = 32'(s >>> 20);
            end
            7'h23: begin
                fmt = 3'd2;
                imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
            end
            7'h63: begin
                fmt = 3'd3;
                imm = 32'((s >>> 31) <<< 12) | (32'(ins[7]) << 11)
                    | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                imm = ins & 32'hFFFF_F000;
            end
            7'h6F: begin
                fmt = 3'd5;
                imm = 32'((s >>> 31) <<< 20) | (32'(ins[19:12]) << 12)
                    | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
            end
            default: ill = 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (bus.wb_en && bus.wb_rd == idx) return bus.wb_data;
        return m_regs[idx];
    endfunction

    // One clock: check in_ready before the edge, advance the model, then
    // check the registered outputs just after the edge.
    task automatic step();
        logic        exp_rdy, acc, ill;
        logic [2:0]  fmt;
        logic [31:0] imm, v1, v2;
        @(negedge clk);
        exp_rdy = !m_vld || bus.out_ready;
        if (!rst) check_eq("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = bus.in_valid && exp_rdy && !bus.flush;
        v1  = ref_read(bus.in_instr[19:15]);
        v2  = ref_read(bus.in_instr[24:20]);
        ref_decode(bus.in_instr, fmt, ill, imm);
        if (rst) begin
            m_vld = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
            m_rd = 0; m_f3 = 0; m_f7 = 0; m_op = 0; m_fmt = 0; m_ill = 0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        end else begin
            if (bus.flush) m_vld = 0;
            else if (acc) begin
                m_vld = 1; m_pc = bus.in_pc; m_rs1 = v1; m_rs2 = v2; m_imm = imm;
                m_rd = bus.in_instr[11:7]; m_f3 = bus.in_instr[14:12];
                m_f7 = bus.in_instr[30]; m_op = bus.in_instr[6:0];
                m_fmt = fmt; m_ill = ill;
            end else if (bus.out_ready) m_vld = 0;
            if (bus.wb_en && bus.wb_rd != 5'd0) m_regs[bus.wb_rd] = bus.wb_data;
        end
        @(posedge clk);
        #1;
        check_eq("out_valid", 32'(bus.out_valid), 32'(m_vld));
        if (m_vld) begin
            check_eq("out_pc", bus.out_pc, m_pc);
            check_eq("out_rs1_data", bus.out_rs1_data, m_rs1);
            check_eq("out_rs2_data", bus.out_rs2_data, m_rs2);
            check_eq("out_imm", bus.out_imm, m_imm);
            check_eq("out_rd", 32'(bus.out_rd), 32'(m_rd));
            check_eq("out_funct3", 32'(bus.out_funct3), 32'(m_f3));
            check_eq("out_funct7b5", 32'(bus.out_funct7b5), 32'(m_f7));
            check_eq("out_opcode", 32'(bus.out_opcode), 32'(m_op));
            check_eq("out_fmt", 32'(bus.out_fmt), 32'(m_fmt));
            check_eq("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
        end
    endtask

    task automatic present(input logic [31:0] pc, input logic [31:0] ins);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_instr = ins;
    endtask

    task automatic check_zero_fields(input string tag);
        check_eq({tag, "_pc"},  bus.out_pc, 32'd0);
        check_eq({tag, "_rs1"}, bus.out_rs1_data, 32'd0);
        check_eq({tag, "_rs2"}, bus.out_rs2_data, 32'd0);
        check_eq({tag, "_imm"}, bus.out_imm, 32'd0);
        check_eq({tag, "_misc"}, {bus.out_rd, bus.out_funct3, bus.out_funct7b5,
                                  bus.out_opcode, bus.out_fmt, bus.out_illegal}, 32'd0);
    endtask

    logic [6:0] ops [12];
    logic [31:0] held_pc;

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h00, 7'h0B};
        rst = 1'b1;
        bus.in_valid = 0; bus.in_pc = 0; bus.in_instr = 0; bus.flush = 0;
        bus.out_ready = 1; bus.wb_en = 0; bus.wb_rd = 0; bus.wb_data = 0;
        m_vld = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;

        // reset
        step(); step();
        rst = 1'b0;
        #1;
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_zero_fields("rst");

        // add x3,x5,x6 from a cleared register file
        present(32'h0, 32'h006281B3);
        step();
        check_eq("add_rs1", bus.out_rs1_data, 32'd0);
        check_eq("add_rs2", bus.out_rs2_data, 32'd0);

        // addi x1,x0,5
        present(32'h10, 32'h00500093);
        step();
        check_eq("addi_imm", bus.out_imm, 32'd5);
        check_eq("addi_rd", 32'(bus.out_rd), 32'd1);
        check_eq("addi_fmt", 32'(bus.out_fmt), 32'd1);
        check_eq("addi_pc", bus.out_pc, 32'h10);

        // write-to-read bypass on x2
        present(32'h14, 32'h002101B3);
        bus.wb_en = 1; bus.wb_rd = 5'd2; bus.wb_data = 32'hDEADBEEF;
        step();
        bus.wb_en = 0;
        check_eq("byp_rs1", bus.out_rs1_data, 32'hDEADBEEF);
        check_eq("byp_rs2", bus.out_rs2_data, 32'hDEADBEEF);
        present(32'h18, 32'h00010233);          // add x4,x2,x0
        step();
        check_eq("x2_later", bus.out_rs1_data, 32'hDEADBEEF);

        // backpressure: 3 stalled cycles, then accept
        held_pc = bus.out_pc;
        bus.out_ready = 0;
        present(32'h1C, 32'h00500093);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("stall_pc", bus.out_pc, held_pc);
        end
        bus.out_ready = 1;
        step();
        check_eq("unstall_pc", bus.out_pc, 32'h1C);

        // negative branch immediate
        present(32'h20, 32'hFE000EE3);
        step();
        check_eq("beq_fmt", 32'(bus.out_fmt), 32'd3);
        check_eq("beq_imm", bus.out_imm, 32'hFFFFFFFC);

        // x0 is not writable
        bus.in_valid = 0;
        bus.wb_en = 1; bus.wb_rd = 5'd0; bus.wb_data = 32'h1234;
        step();
        bus.wb_en = 0;
        present(32'h24, 32'h000002B3);          // add x5,x0,x0
        step();
        check_eq("x0_read", bus.out_rs1_data, 32'd0);

        // illegal opcode
        present(32'h28, 32'h0000007F);
        step();
        check_eq("ill_flag", 32'(bus.out_illegal), 32'd1);
        check_eq("ill_imm", bus.out_imm, 32'd0);

        // flush with a held bundle and a presented instruction
        present(32'h2C, 32'h00500093);
        bus.flush = 1;
        step();
        bus.flush = 0;
        bus.in_valid = 0;
        check_eq("flush_valid", 32'(bus.out_valid), 32'd0);

        // rst together with flush behaves as reset
        present(32'h30, 32'h00500093);
        rst = 1; bus.flush = 1;
        step();
        rst = 0; bus.flush = 0; bus.in_valid = 0;
        check_eq("rstflush_valid", 32'(bus.out_valid), 32'd0);
        check_zero_fields("rstflush");

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] ins;
            ins = $urandom();
            ins[6:0] = ops[$urandom_range(0, 11)];
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_pc     = $urandom();
            bus.in_instr  = ins;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.flush     = ($urandom_range(0, 15) == 0);
            bus.wb_en     = ($urandom_range(0, 1) == 1);
            bus.wb_rd     = ($urandom_range(0, 2) == 0) ? ins[19:15] : 5'($urandom());
            bus.wb_data   = $urandom();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
